// File: rtl/timer.sv
// Memory-mapped divider/timer block (DIV, TIMA, TMA, TAC at 0xFF04-0xFF07) with overflow interrupt.
// Define TIMER_RELOAD_DELAY_EN to hold TIMA at 0x00 for one cycle before the TMA reload and irq.
module timer (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addr_ext,
  inout  wire  [7:0]  data_ext,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic        timer_irq
);

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  logic [15:0] div_cnt;
  logic [7:0]  tima;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic        prev_sig;

`ifdef TIMER_RELOAD_DELAY_EN
  typedef enum logic [0:0] {ST_RUN, ST_PENDING} state_t;
  state_t state;
`endif

  logic        hit_div, hit_tima, hit_tma, hit_tac, rd_hit;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic [7:0]  tma_next;
  logic        sel_bit;
  logic        cur_sig;
  logic        tick;

  assign hit_div  = (addr_ext == ADDR_DIV);
  assign hit_tima = (addr_ext == ADDR_TIMA);
  assign hit_tma  = (addr_ext == ADDR_TMA);
  assign hit_tac  = (addr_ext == ADDR_TAC);
  assign rd_hit   = hit_div | hit_tima | hit_tma | hit_tac;

  assign wr_data = data_ext;
  assign wr_div  = mem_we & hit_div;
  assign wr_tima = mem_we & hit_tima;
  assign wr_tma  = mem_we & hit_tma;
  assign wr_tac  = mem_we & hit_tac;

  // A TMA write landing in the reload cycle must be the value that reaches TIMA.
  assign tma_next = wr_tma ? wr_data : tma;

  always_comb begin
    rd_data = 8'h00;
    if (hit_div)       rd_data = div_cnt[15:8];
    else if (hit_tima) rd_data = tima;
    else if (hit_tma)  rd_data = tma;
    else if (hit_tac)  rd_data = {5'b11111, tac};
  end

  assign data_ext = (mem_re && rd_hit) ? rd_data : 8'hzz;

  always_comb begin
    case (tac[1:0])
      2'b00:   sel_bit = div_cnt[9];
      2'b01:   sel_bit = div_cnt[3];
      2'b10:   sel_bit = div_cnt[5];
      default: sel_bit = div_cnt[7];
    endcase
  end

  // Falling edge of the gated bit, so DIV clears and TAC changes can also tick.
  assign cur_sig = tac[2] & sel_bit;
  assign tick    = prev_sig & ~cur_sig;

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= 16'h0000;
      tima      <= 8'h00;
      tma       <= 8'h00;
      tac       <= 3'b000;
      prev_sig  <= 1'b0;
      timer_irq <= 1'b0;
`ifdef TIMER_RELOAD_DELAY_EN
      state     <= ST_RUN;
`endif
    end else begin
      prev_sig  <= cur_sig;
      div_cnt   <= wr_div ? 16'h0000 : div_cnt + 16'd1;
      timer_irq <= 1'b0;
      if (wr_tma) tma <= wr_data;
      if (wr_tac) tac <= wr_data[2:0];
`ifdef TIMER_RELOAD_DELAY_EN
      if (state == ST_PENDING) begin
        state <= ST_RUN;
        if (wr_tima) begin
          tima <= wr_data;
        end else begin
          tima      <= tma_next;
          timer_irq <= 1'b1;
        end
      end else if (wr_tima) begin
        tima <= wr_data;
      end else if (tick) begin
        tima <= tima + 8'd1;
        if (tima == 8'hFF) state <= ST_PENDING;
      end
`else
      if (wr_tima) begin
        tima <= wr_data;
      end else if (tick) begin
        if (tima == 8'hFF) begin
          tima      <= tma_next;
          timer_irq <= 1'b1;
        end else begin
          tima <= tima + 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_timer.sv
// Bench for timer: directed scenarios plus randomized bus traffic against a cycle-level reference model.
module tb_timer;

  logic        clock;
  logic        reset;
  logic [15:0] addr_ext;
  logic        mem_we;
  logic        mem_re;
  logic        timer_irq;
  logic        drv_en;
  logic [7:0]  drv_data;
  tri1  [7:0]  data_ext;

  assign data_ext = drv_en ? drv_data : 8'hzz;

  timer dut (
    .clock     (clock),
    .reset     (reset),
    .addr_ext  (addr_ext),
    .data_ext  (data_ext),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .timer_irq (timer_irq)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  int irq_seen = 0;
  logic [7:0] last_rd;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: registers as plain integers, updated once per clock
  int m_div, m_tima, m_tma, m_tac;
  bit m_prev, m_pend, m_irq;

  function automatic logic [7:0] m_read(input logic [15:0] a);
    case (a)
      16'hFF04: return 8'(m_div / 256);
      16'hFF05: return 8'(m_tima);
      16'hFF06: return 8'(m_tma);
      16'hFF07: return 8'(248 + m_tac);
      default:  return 8'hFF;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit we, input logic [15:0] a, input int d);
    int  period_log2;
    bit  level, tick_now, w_tima;
    int  new_tma;
    if (rst) begin
      m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_prev = 0; m_pend = 0; m_irq = 0;
      return;
    end
    case (m_tac % 4)
      0: period_log2 = 9;
      1: period_log2 = 3;
      2: period_log2 = 5;
      default: period_log2 = 7;
    endcase
    level    = (m_tac >= 4) && (((m_div >> period_log2) % 2) == 1);
    tick_now = m_prev && !level;
    w_tima   = we && (a == 16'hFF05);
    new_tma  = (we && a == 16'hFF06) ? d : m_tma;
    m_irq    = 0;
    if (m_pend) begin
      m_pend = 0;
      if (w_tima) m_tima = d;
      else begin m_tima = new_tma; m_irq = 1; end
    end else if (w_tima) begin
      m_tima = d;
    end else if (tick_now) begin
      if (m_tima == 255) begin
`ifdef TIMER_RELOAD_DELAY_EN
        m_tima = 0;
        m_pend = 1;
`else
        m_tima = new_tma;
        m_irq  = 1;
`endif
      end else begin
        m_tima = m_tima + 1;
      end
    end
    m_tma = new_tma;
    if (we && a == 16'hFF07) m_tac = d % 8;
    m_div  = (we && a == 16'hFF04) ? 0 : (m_div + 1) % 65536;
    m_prev = level;
  endtask

  // driver tasks
  task automatic cyc(input bit rst, input bit we, input bit re, input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    reset    = rst;
    mem_we   = we;
    mem_re   = re;
    addr_ext = a;
    drv_en   = we;
    drv_data = d;
    #1;
    if (re) begin
      last_rd = data_ext;
      check_eq("read", data_ext, m_read(a));
    end
    @(posedge clock);
    model_step(rst, we, a, int'(d));
    #1;
    check_eq("irq", {7'b0, timer_irq}, {7'b0, m_irq});
    if (timer_irq) irq_seen++;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cyc(1'b0, 1'b0, 1'b1, a, 8'h00);
    check_eq(tag, last_rd, exp);
  endtask

  // TAC=05, TMA=A0, TIMA=FE, then DIV cleared so the next cycles see div_cnt = 0,1,2,...
  task automatic overflow_setup();
    do_reset();
    wr(16'hFF07, 8'h05);
    wr(16'hFF06, 8'hA0);
    wr(16'hFF05, 8'hFE);
    wr(16'hFF04, 8'h00);
  endtask

  initial begin
    int irq0, guard, sel, r;
    logic [15:0] a;
    logic [7:0]  d;
    reset = 1'b1; mem_we = 1'b0; mem_re = 1'b0; addr_ext = 16'h0000;
    drv_en = 1'b0; drv_data = 8'h00; last_rd = 8'h00;

    // reset values and unmapped read
    do_reset();
    rd_chk("tac_reset", 16'hFF07, 8'hF8);
    rd_chk("tima_reset", 16'hFF05, 8'h00);
    rd_chk("unmapped_hiz", 16'hFF00, 8'hFF);

    // DIV free-run and clear
    do_reset();
    idle(256);
    rd_chk("div_256", 16'hFF04, 8'h01);
    wr(16'hFF04, 8'h5A);
    rd_chk("div_clear", 16'hFF04, 8'h00);

    // overflow with reload from TMA, single irq pulse
    overflow_setup();
    irq0 = irq_seen;
    idle(33);
`ifdef TIMER_RELOAD_DELAY_EN
    rd_chk("tima_pending", 16'hFF05, 8'h00);
`else
    rd_chk("tima_reloaded", 16'hFF05, 8'hA0);
`endif
    idle(6);
    rd_chk("tima_after_ovf", 16'hFF05, 8'hA0);
    check_eq("irq_count_ovf", 8'(irq_seen - irq0), 8'd1);

    // disabling the timer while the selected bit is high causes a tick
    do_reset();
    wr(16'hFF07, 8'h05);
    guard = 0;
    while (((m_div >> 3) % 2) == 0 && guard < 40) begin
      idle(1);
      guard++;
    end
    check_eq("bit3_wait_bound", 8'(guard < 40), 8'd1);
    wr(16'hFF07, 8'h00);
    idle(1);
    rd_chk("tac_disable_tick", 16'hFF05, 8'h01);

`ifdef TIMER_RELOAD_DELAY_EN
    // TIMA write in the pending cycle cancels reload and irq
    overflow_setup();
    irq0 = irq_seen;
    idle(33);
    wr(16'hFF05, 8'h33);
    idle(3);
    rd_chk("pending_cancel", 16'hFF05, 8'h33);
    check_eq("irq_count_cancel", 8'(irq_seen - irq0), 8'd0);
`endif

    // reset during the overflow / pending cycle
    overflow_setup();
`ifdef TIMER_RELOAD_DELAY_EN
    idle(33);
`else
    idle(32);
`endif
    do_reset();
    irq0 = irq_seen;
    idle(100);
    rd_chk("tima_after_reset", 16'hFF05, 8'h00);
    check_eq("irq_count_reset", 8'(irq_seen - irq0), 8'd0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      sel = $urandom_range(0, 19);
      if (sel < 8)       a = 16'hFF05;
      else if (sel < 12) a = 16'hFF07;
      else if (sel < 16) a = 16'hFF06;
      else if (sel < 17) a = 16'hFF04;
      else               a = 16'($urandom_range(0, 65535));
      if (a == 16'hFF05 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(8'hF8, 8'hFF));
      else if (a == 16'hFF07 && $urandom_range(0, 1) == 1) d = 8'h05;
      else d = 8'($urandom_range(0, 255));
      if (r == 0)      do_reset();
      else if (r < 8)  wr(a, d);
      else if (r < 50) cyc(1'b0, 1'b0, 1'b1, a, 8'h00);
      else             idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 addr_ext  input  16  external bus address driven by bus initiator.
REQ-005 data_ext  inout  8  shared external data bus.
REQ-006 mem_we  input  1  bus write strobe, sampled at posedge clock.
REQ-007 mem_re  input  1  bus read strobe, combinational read.
REQ-008 timer_irq  output  1  one-cycle timer interrupt request pulse.

Function
REQ-009 Register map SHALL be: 0xFF04 DIV, 0xFF05 TIMA, 0xFF06 TMA, 0xFF07 TAC; all other addresses ignored.
REQ-010 data_ext SHALL be driven only when mem_re=1 and addr_ext hits the map, else high-Z; read data combinational, same cycle.
REQ-011 TAC SHALL read as {5'b11111, tac[2:0]}; DIV reads div_cnt[15:8]; TIMA, TMA read stored values.
REQ-012 Writes SHALL take effect at posedge clock when mem_we=1 and address hits; mem_we and mem_re never both asserted by initiator.
REQ-013 div_cnt SHALL be a 16-bit free-running counter incrementing every clock, wrapping 0xFFFF->0x0000.
REQ-014 Any write to DIV SHALL clear div_cnt to 0x0000 regardless of write data.
REQ-015 Selected bit SHALL be div_cnt[9] (tac[1:0]=00, 1024 clocks), [3] (01, 16), [5] (10, 64), [7] (11, 256).
REQ-016 tick SHALL assert when (tac[2] AND selected bit) goes 1->0 between consecutive cycles; covers DIV writes and TAC changes causing falling edges.
REQ-017 On tick, TIMA SHALL increment by 1 (8-bit).
REQ-018 Overflow (tick with TIMA=0xFF) SHALL reload TIMA from TMA and pulse timer_irq for exactly one cycle, timing per REQ-024/025.
REQ-019 CPU write to TIMA coinciding with tick SHALL win; no increment, no overflow.
REQ-020 CPU write to TMA in the reload cycle SHALL load the new TMA value into TIMA.
REQ-021 timer_irq SHALL be registered, high one cycle per overflow, never level.

Reset
REQ-022 On reset: div_cnt=0x0000, TIMA=0x00, TMA=0x00, tac=3'b000, timer_irq=0, reload-pending state cleared, previous-edge flag=0.
REQ-023 Reset asserted mid-count or during pending reload SHALL cancel all pending reload/interrupt; no irq after reset release until a new overflow.

Configuration
REQ-024 With TIMER_RELOAD_DELAY_EN defined: overflow SHALL leave TIMA=0x00 for one cycle (state PENDING), then next cycle load TMA and pulse timer_irq; CPU write to TIMA during PENDING SHALL cancel reload and irq.
REQ-025 Without TIMER_RELOAD_DELAY_EN: overflow SHALL load TMA into TIMA in the same posedge and pulse timer_irq in the following cycle; no PENDING state.

Verification
REQ-026 Reset, then read 0xFF07 -> data_ext=0xF8; read 0xFF05 -> 0x00; read 0xFF00 -> high-Z.
REQ-027 Free-run 256 clocks after reset then read 0xFF04 -> 0x01; write 0xFF04 any value, next read -> 0x00.
REQ-028 TAC=0x05, TMA=0xA0, TIMA=0xFE -> after 32 clocks TIMA=0xA0 and exactly one timer_irq pulse (delay version: TIMA=0x00 for one cycle first).
REQ-029 TAC=0x05, div_cnt[3]=1, write TAC=0x00 -> falling enable edge increments TIMA by 1.
REQ-030 Delay build: overflow then write TIMA=0x33 in PENDING cycle -> TIMA=0x33, no timer_irq.
REQ-031 Assert reset in PENDING/overflow cycle -> TIMA=0x00, timer_irq stays 0 for 100 cycles with TAC=0.
